// File: rtl/spi_txn_scheduler_pkg.sv
// ============================================================================
// spi_txn_scheduler_pkg : shared widths, timing limits and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_txn_scheduler_pkg;

    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int BRIGHTNESS_WIDTH   = 7;

    localparam int SCHED_GAP_CYC = 4;
    localparam int SCHED_TO_CYC  = 1024;

    // Requester index width; covers up to four requesters.
    localparam int IDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARB        = 3'd1,
        ST_LAUNCH     = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_RESP       = 3'd5,
        ST_GAP        = 3'd6
    } sched_state_e;

    // (base + off) mod n, for base and off both below n.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s[IDX_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick starting at a given pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import spi_txn_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_gnt_valid,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    always_comb begin
        dbl         = {i_valid, i_valid};
        rot         = NUM_REQ'(dbl >> i_ptr);
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = wrap_idx(int'(i_ptr), k, NUM_REQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_txn_scheduler.sv
// ============================================================================
// spi_txn_scheduler : round-robin sequencer of requester frames onto one SPI master
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_txn_scheduler
    import spi_txn_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CMD_W   = CMD_BITS,
    parameter int ADDR_W  = ADDR_BITS,
    parameter int DATA_W  = PAYLOAD_BITS,
    parameter int FRAME_W = MASTER_FRAME_WIDTH,
    parameter int RESP_W  = BRIGHTNESS_WIDTH,
    parameter int GAP_CYC = SCHED_GAP_CYC,
    parameter int TO_CYC  = SCHED_TO_CYC
) (
    input  logic                      sysclk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*CMD_W-1:0]  req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [RESP_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic                      spi_tx_enb,
    output logic [FRAME_W-1:0]        spi_i_frame,
    input  logic                      spi_rx_dv,
    input  logic [RESP_W-1:0]         spi_o_frame,
    output logic                      busy,
    output logic [1:0]                grant_id
);

    localparam int WD_W  = $clog2(TO_CYC) + 1;
    localparam int GAP_W = $clog2(GAP_CYC) + 1;

    sched_state_e        state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [RESP_W-1:0]   resp_data_q, resp_data_d;
    logic                err_q, err_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [FRAME_W-1:0]  pick_frame;
    logic                wd_expired;
    logic [WD_W-1:0]     wd_inc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_valid     (req_valid),
        .i_ptr       (ptr_q),
        .o_gnt_valid (pick_valid),
        .o_gnt_idx   (pick_idx)
    );

    always_comb begin
        pick_frame = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_frame = {req_cmd[i*CMD_W +: CMD_W],
                              req_addr[i*ADDR_W +: ADDR_W],
                              req_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    // Watchdog saturates at its limit so a stuck wait can never wrap around.
    assign wd_expired = (wd_q == WD_W'(TO_CYC));
    assign wd_inc     = wd_expired ? wd_q : wd_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        frame_d     = frame_q;
        wd_d        = wd_q;
        gap_d       = gap_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pick_valid) begin
                    frame_d = pick_frame;
                    grant_d = pick_idx;
                    ptr_d   = wrap_idx(int'(pick_idx), 1, NUM_REQ);
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wd_d    = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!spi_rx_dv) begin
                    wd_d    = '0;
                    state_d = ST_WAIT_DONE;
                end else if (wd_expired) begin
                    err_d       = 1'b1;
                    resp_data_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ST_WAIT_DONE: begin
                // The master clears its response one cycle after CS rises.
                if (spi_rx_dv) begin
                    err_d       = 1'b0;
                    resp_data_d = spi_o_frame;
                    state_d     = ST_RESP;
                end else if (wd_expired) begin
                    err_d       = 1'b1;
                    resp_data_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ST_RESP: begin
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            frame_q     <= '0;
            wd_q        <= '0;
            gap_q       <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            frame_q     <= frame_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_out
            assign req_ready[gi]  = (state_q == ST_ARB) && pick_valid && (pick_idx == IDX_W'(gi));
            assign resp_valid[gi] = (state_q == ST_RESP) && (grant_q == IDX_W'(gi));
        end
    endgenerate

    assign resp_data   = resp_data_q;
    assign resp_err    = (state_q == ST_RESP) && err_q;
    assign spi_tx_enb  = (state_q == ST_LAUNCH);
    assign spi_i_frame = frame_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;

endmodule

`default_nettype wire

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
Sequences SPI transactions onto the single SPI master for NUM_REQ requesters, arbitrating between them round-robin. For each granted request it packs command, address and payload into one master frame and launches it with a one-cycle tx_enb pulse. It tracks the master's chip-select window through its rx_dv output, captures the slave response, and returns it to the owning requester. A watchdog and an inter-frame gap counter guarantee forward progress and a minimum CS-high time.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
CMD_W, 8, command field width (matches CMD_BITS)
ADDR_W, 8, address field width (matches ADDR_BITS)
DATA_W, 8, payload width (matches PAYLOAD_BITS)
FRAME_W, 24, CMD_W+ADDR_W+DATA_W (matches MASTER_FRAME_WIDTH)
RESP_W, 7, response width (matches BRIGHTNESS_WIDTH)
GAP_CYC, 4, minimum sysclk cycles between the end of one transaction and the next launch
TO_CYC, 1024, watchdog limit in sysclk cycles per wait state

Ports:
sysclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_cmd  in  NUM_REQ*CMD_W  packed commands; requester i occupies bits [i*CMD_W +: CMD_W]
req_addr  in  NUM_REQ*ADDR_W  packed addresses
req_data  in  NUM_REQ*DATA_W  packed payloads
resp_valid  out  NUM_REQ  one-cycle response strobe to the owning requester
resp_data  out  RESP_W  captured slave response
resp_err  out  1  qualifies resp_valid; 1 = watchdog timeout
spi_tx_enb  out  1  launch pulse to the SPI master
spi_i_frame  out  FRAME_W  frame to the SPI master
spi_rx_dv  in  1  master idle indicator (1 = CS deasserted)
spi_o_frame  in  RESP_W  master response
busy  out  1  high in any state other than IDLE
grant_id  out  2  index of the current or last granted requester

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; all outputs 0; spi_i_frame=0; round-robin pointer=0 (requester 0 has highest priority first); counters cleared.
- Reset mid-transaction: abandons the transaction with no response. The master is not reset by this block.
- Handshake: a request transfers when req_valid[i] & req_ready[i].
  - The requester holds valid, cmd, addr and data stable until the transfer.
  - It must not issue a new request until it has received its resp_valid.
- Frame format: {cmd, addr, data}, MSB first. The command occupies spi_i_frame[FRAME_W-1 -: CMD_W].
- FSM:
  - IDLE: if any req_valid, go to ARB.
  - ARB:
    - Pick the first valid requester starting at pointer and wrapping. Assert req_ready for that requester only, for exactly 1 cycle.
    - Latch the frame and grant_id. Set pointer = grant+1 mod NUM_REQ.
    - Go to LAUNCH.
  - LAUNCH: spi_tx_enb=1 for exactly 1 cycle, with spi_i_frame valid and held stable until the next ARB. Clear the watchdog. Go to WAIT_START.
  - WAIT_START:
    - On spi_rx_dv==0, go to WAIT_DONE and clear the watchdog.
    - If the watchdog reaches TO_CYC, go to RESP with err=1.
  - WAIT_DONE:
    - On the first cycle spi_rx_dv==1, capture spi_o_frame into resp_data and go to RESP with err=0. This capture cycle is mandatory: the master clears its response one cycle later.
    - If the watchdog reaches TO_CYC, go to RESP with err=1 and resp_data=0.
  - RESP: resp_valid[grant_id]=1 for 1 cycle, with resp_err set accordingly. Go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE. spi_tx_enb stays 0 throughout.
- Minimum latency: ARB to first cycle of WAIT_START is 2 cycles. Total latency = 3 + CS window + 1 + GAP_CYC + 1 cycles.
- Simultaneous valids are resolved by the pointer only. Requests arriving during a transaction wait, and no request is dropped.
- spi_rx_dv already low when entering WAIT_START (stale): treated as start. It is the caller's error, and the watchdog covers it.
- Watchdog counter width is clog2(TO_CYC)+1; it saturates and never wraps.

Decomposition:
- Shared header params.vh gains SCHED_GAP_CYC, SCHED_TO_CYC and the FSM state encodings. It reuses CMD_BITS, ADDR_BITS, PAYLOAD_BITS, MASTER_FRAME_WIDTH and BRIGHTNESS_WIDTH as parameter defaults.
- One sub-module, rr_arbiter: combinational round-robin pick given valid and pointer, with the registered pointer held in the parent.

Test Plan:
- Single request: requester 0 sends cmd=0xA5, addr=0x3C, data=0x81; the SPI master model is paired with a slave returning 0x55. Required: spi_i_frame=0xA53C81, exactly one tx_enb pulse, resp_valid[0] once, resp_data=0x55, resp_err=0.
- Contention: both requesters valid at the same time after reset. Required: grant order 0, 1. On back-to-back re-requests, the order alternates 0, 1, 0, 1, and spi_rx_dv stays high for at least GAP_CYC cycles between CS windows.
- Dead master: spi_rx_dv tied to 1. Required: after TO_CYC=1024 cycles in WAIT_START, resp_valid with resp_err=1 and resp_data=0, then the block returns to IDLE.
- Hung CS: spi_rx_dv held low after start. Required: timeout in WAIT_DONE with resp_err=1.
- Capture timing: the model drops spi_o_frame to 0 one cycle after spi_rx_dv rises. Required: resp_data still equals the pre-drop value 0x2A.
- Reset mid-transaction: assert rst_n=0 during WAIT_DONE. Required: all outputs 0 immediately (asynchronously), no resp_valid, and the pointer returns to 0.
